// File: rtl/bvh_fetch_arbiter.sv
// rtl/bvh_fetch_arbiter.sv - round-robin arbiter sharing node/leaf RAM read ports among BVH traversal cores
module bvh_fetch_arbiter #(
    parameter int NUM_CORES       = 4,
    parameter int INDEX_WIDTH     = 16,
    parameter int NODE_ADDR_WIDTH = 10,
    parameter int LEAF_ADDR_WIDTH = 10,
    parameter int NODE_DATA_WIDTH = 224,
    parameter int LEAF_DATA_WIDTH = 232,
    parameter int RAM_LATENCY     = 1,
    parameter int STALL_CNT_WIDTH = 32,
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_CORES-1:0]             req_valid,
    input  logic [NUM_CORES*INDEX_WIDTH-1:0] req_index,
    output logic [NUM_CORES-1:0]             req_grant,
    output logic                             node_ram_en,
    output logic [NODE_ADDR_WIDTH-1:0]       node_ram_addr,
    input  logic [NODE_DATA_WIDTH-1:0]       node_ram_rdata,
    output logic                             leaf_ram_en,
    output logic [LEAF_ADDR_WIDTH-1:0]       leaf_ram_addr,
    input  logic [LEAF_DATA_WIDTH-1:0]       leaf_ram_rdata,
    output logic                             resp_valid,
    output logic [CW-1:0]                    resp_core,
    output logic                             resp_is_leaf,
    output logic [LEAF_DATA_WIDTH-1:0]       resp_data,
    output logic                             busy,
    output logic [STALL_CNT_WIDTH-1:0]       stall_count
);
    localparam int ECW = $clog2(NUM_CORES + 1);

    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] clr_mask;
    logic [CW-1:0]        rr_ptr;
    logic [CW-1:0]        winner;
    logic                 found;
    logic [ECW-1:0]       elig_cnt;
    logic                 win_leaf;
    logic [NODE_ADDR_WIDTH-1:0] win_node_addr;
    logic [LEAF_ADDR_WIDTH-1:0] win_leaf_addr;

    // Shift pipe tracking each RAM read; stage 0 is the issue cycle.
    logic [RAM_LATENCY:0] pipe_valid;
    logic [RAM_LATENCY:0] pipe_leaf;
    logic [CW-1:0]        pipe_core [0:RAM_LATENCY];

    always_comb begin
        int idx;
        idx      = 0;
        eligible = req_valid & ~pending;
        found    = 1'b0;
        winner   = '0;
        elig_cnt = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = CW'(idx);
            end
            elig_cnt = elig_cnt + ECW'(eligible[i]);
        end
        req_grant     = found ? (NUM_CORES'(1) << winner) : '0;
        win_leaf      = req_index[winner*INDEX_WIDTH + INDEX_WIDTH - 1];
        win_node_addr = req_index[winner*INDEX_WIDTH +: NODE_ADDR_WIDTH];
        win_leaf_addr = ~req_index[winner*INDEX_WIDTH +: LEAF_ADDR_WIDTH];
        clr_mask      = resp_valid ? (NUM_CORES'(1) << resp_core) : '0;
    end

    assign busy = |pending;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending       <= '0;
            rr_ptr        <= '0;
            node_ram_en   <= 1'b0;
            node_ram_addr <= '0;
            leaf_ram_en   <= 1'b0;
            leaf_ram_addr <= '0;
            pipe_valid    <= '0;
            pipe_leaf     <= '0;
            for (int k = 0; k <= RAM_LATENCY; k++) pipe_core[k] <= '0;
            resp_valid    <= 1'b0;
            resp_core     <= '0;
            resp_is_leaf  <= 1'b0;
            resp_data     <= '0;
            stall_count   <= '0;
        end else begin
            // A core's own grant and response never coincide, so set/clear cannot collide.
            pending <= (pending & ~clr_mask) | req_grant;
            if (found)
                rr_ptr <= (winner == CW'(NUM_CORES - 1)) ? '0 : winner + CW'(1);

            node_ram_en <= found && !win_leaf;
            if (found && !win_leaf) node_ram_addr <= win_node_addr;
            leaf_ram_en <= found && win_leaf;
            if (found && win_leaf) leaf_ram_addr <= win_leaf_addr;

            pipe_valid[0] <= found;
            pipe_leaf[0]  <= win_leaf;
            pipe_core[0]  <= winner;
            for (int k = 1; k <= RAM_LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_leaf[k]  <= pipe_leaf[k-1];
                pipe_core[k]  <= pipe_core[k-1];
            end

            resp_valid <= pipe_valid[RAM_LATENCY];
            if (pipe_valid[RAM_LATENCY]) begin
                resp_core    <= pipe_core[RAM_LATENCY];
                resp_is_leaf <= pipe_leaf[RAM_LATENCY];
                resp_data    <= pipe_leaf[RAM_LATENCY] ? leaf_ram_rdata
                                                       : LEAF_DATA_WIDTH'(node_ram_rdata);
            end

            if (elig_cnt >= ECW'(2) && stall_count != '1)
                stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end
endmodule
